// File: rtl/apb_mux_pkg.sv
// Shared types and helpers for the N-to-1 APB arbitration mux.
package apb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Index width for n masters; a single master still gets a 1-bit index.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Request-vector arbiter: round-robin with internal pointer, or fixed priority (lowest index wins).
module apb_rr_arbiter
  import apb_mux_pkg::*;
#(
  parameter int unsigned  N    = 4,
  parameter int unsigned  MODE = ARB_RR,
  localparam int unsigned IW   = ptr_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          gnt_en,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] ptr;

  // First requester found scanning upward from ptr (or from 0 in fixed mode).
  always_comb begin : pick
    int unsigned idx;
    idx       = 0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (MODE == ARB_FIXED) ? k : (32'(ptr) + k) % N;
      if (!gnt_valid && req[IW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_en && gnt_valid && MODE == ARB_RR) begin
      ptr <= IW'((32'(gnt_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/apb_arb_mux.sv
// N-master to 1-slave APB4 stage: arbitrates in IDLE, replays the captured request on the slave port.
// Optional ACCESS watchdog enabled by defining APB_MUX_TIMEOUT_EN.
module apb_arb_mux
  import apb_mux_pkg::*;
#(
  parameter int unsigned  NUM_APB_MASTERS = 4,
  parameter int unsigned  APB_ADDR_WIDTH  = 32,
  parameter int unsigned  APB_DATA_WIDTH  = 32,
  parameter int unsigned  APB_STRB_WIDTH  = APB_DATA_WIDTH / 8,
  parameter int unsigned  ARB_MODE        = ARB_RR,
  parameter int unsigned  TIMEOUT_CYCLES  = 256,
  localparam int unsigned IW              = ptr_width(NUM_APB_MASTERS)
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      PSEL_s    [NUM_APB_MASTERS],
  input  logic [APB_ADDR_WIDTH-1:0] PADDR_s   [NUM_APB_MASTERS],
  input  logic                      PWRITE_s  [NUM_APB_MASTERS],
  input  logic [APB_DATA_WIDTH-1:0] PWDATA_s  [NUM_APB_MASTERS],
  input  logic                      PENABLE_s [NUM_APB_MASTERS],
  input  logic [APB_STRB_WIDTH-1:0] PSTRB_s   [NUM_APB_MASTERS],
  input  logic [2:0]                PPROT_s   [NUM_APB_MASTERS],
  output logic [APB_DATA_WIDTH-1:0] PRDATA_s  [NUM_APB_MASTERS],
  output logic                      PREADY_s  [NUM_APB_MASTERS],
  output logic                      PSLVERR_s [NUM_APB_MASTERS],
  output logic                      PSEL_m,
  output logic [APB_ADDR_WIDTH-1:0] PADDR_m,
  output logic                      PWRITE_m,
  output logic [APB_DATA_WIDTH-1:0] PWDATA_m,
  output logic                      PENABLE_m,
  output logic [APB_STRB_WIDTH-1:0] PSTRB_m,
  output logic [2:0]                PPROT_m,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA_m,
  input  logic                      PREADY_m,
  input  logic                      PSLVERR_m,
  output logic [IW-1:0]             GNT_IDX,
  output logic                      TIMEOUT_EVT
);

  state_t                     state;
  logic [NUM_APB_MASTERS-1:0] req;
  logic [IW-1:0]              arb_idx;
  logic                       arb_valid;
  logic                       timeout_c;
  logic                       done_c;
  logic                       unused_penable;

  // The slave-side phase comes from the FSM, so master PENABLE is deliberately ignored.
  always_comb begin
    req            = '0;
    unused_penable = 1'b0;
    for (int i = 0; i < NUM_APB_MASTERS; i++) begin
      req[i]         = PSEL_s[i];
      unused_penable = unused_penable ^ PENABLE_s[i];
    end
  end

  apb_rr_arbiter #(
    .N    (NUM_APB_MASTERS),
    .MODE (ARB_MODE)
  ) u_arb (
    .clk       (PCLK),
    .rst       (PRESET),
    .req       (req),
    .gnt_en    (state == IDLE),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

`ifdef APB_MUX_TIMEOUT_EN
  localparam int unsigned TW = ptr_width(TIMEOUT_CYCLES);

  logic [TW-1:0] wait_cnt;

  // Counts stalled ACCESS cycles; held at zero outside ACCESS so each transfer starts fresh.
  always_ff @(posedge PCLK) begin
    if (PRESET || state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!PREADY_m) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_c   = (state == ACCESS) && !PREADY_m && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign TIMEOUT_EVT = timeout_c;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = 1'(TIMEOUT_CYCLES);
  assign timeout_c          = 1'b0;
  assign TIMEOUT_EVT        = 1'b0;
`endif

  assign done_c = (state == ACCESS) && (PREADY_m || timeout_c);

  // Transfer FSM with capture registers; a grant freezes the winner's request until completion.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL_m    <= 1'b0;
      PENABLE_m <= 1'b0;
      PADDR_m   <= '0;
      PWRITE_m  <= 1'b0;
      PWDATA_m  <= '0;
      PSTRB_m   <= '0;
      PPROT_m   <= '0;
      GNT_IDX   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            state     <= SETUP;
            PSEL_m    <= 1'b1;
            PENABLE_m <= 1'b0;
            PADDR_m   <= PADDR_s[arb_idx];
            PWRITE_m  <= PWRITE_s[arb_idx];
            PWDATA_m  <= PWDATA_s[arb_idx];
            PSTRB_m   <= PSTRB_s[arb_idx];
            PPROT_m   <= PPROT_s[arb_idx];
            GNT_IDX   <= arb_idx;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          PENABLE_m <= 1'b1;
        end
        ACCESS: begin
          if (done_c) begin
            state     <= IDLE;
            PSEL_m    <= 1'b0;
            PENABLE_m <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          PSEL_m    <= 1'b0;
          PENABLE_m <= 1'b0;
        end
      endcase
    end
  end

  // Response demux: only the granted master sees its completion, a watchdog kill returns error with zero data.
  always_comb begin
    for (int i = 0; i < NUM_APB_MASTERS; i++) begin
      PREADY_s[i]  = 1'b0;
      PRDATA_s[i]  = '0;
      PSLVERR_s[i] = 1'b0;
      if (done_c && IW'(i) == GNT_IDX) begin
        PREADY_s[i]  = 1'b1;
        PRDATA_s[i]  = timeout_c ? '0 : PRDATA_m;
        PSLVERR_s[i] = timeout_c | PSLVERR_m;
      end
    end
  end

endmodule

// File: tb/tb_apb_arb_mux.sv
// Bench for apb_arb_mux: a round-robin and a fixed-priority instance share master stimulus,
// each checked every cycle against a transaction-level model plus directed literal expectations.
module tb_apb_arb_mux;

  localparam int NM = 4;
  localparam int TO = 8;
`ifdef APB_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        psel    [NM];
  logic [31:0] paddr   [NM];
  logic        pwrite  [NM];
  logic [31:0] pwdata  [NM];
  logic        penable [NM];
  logic [3:0]  pstrb   [NM];
  logic [2:0]  pprot   [NM];
  logic [31:0] prdata_m;
  logic        pslverr_m;
  logic        pready_m [2];

  logic        o_psel_m [2], o_penable_m [2], o_pwrite_m [2], o_timeout [2];
  logic [31:0] o_paddr_m [2], o_pwdata_m [2];
  logic [3:0]  o_pstrb_m [2];
  logic [2:0]  o_pprot_m [2];
  logic [1:0]  o_gnt [2];
  logic        o_pready_s [2][NM];
  logic        o_pslverr_s [2][NM];
  logic [31:0] o_prdata_s [2][NM];

  int checks = 0;
  int errors = 0;
  int waits  = 0;

  // Transaction-level model state per instance (0 = round-robin, 1 = fixed priority).
  bit          m_busy [2] = '{0, 0};
  bit          m_acc  [2] = '{0, 0};
  int          m_g    [2] = '{0, 0};
  int          m_ptr  [2] = '{0, 0};
  int          m_wait [2] = '{0, 0};
  logic [31:0] m_addr [2] = '{0, 0};
  logic [31:0] m_wdat [2] = '{0, 0};
  logic        m_wr   [2] = '{0, 0};
  logic [3:0]  m_strb [2] = '{0, 0};
  logic [2:0]  m_prot [2] = '{0, 0};

  int glog_rr [$];
  int glog_fx [$];
  int rcnt [2][NM];

  always #5 PCLK = ~PCLK;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    apb_arb_mux #(
      .NUM_APB_MASTERS (NM),
      .APB_ADDR_WIDTH  (32),
      .APB_DATA_WIDTH  (32),
      .APB_STRB_WIDTH  (4),
      .ARB_MODE        (k),
      .TIMEOUT_CYCLES  (TO)
    ) u_dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .PSEL_s      (psel),
      .PADDR_s     (paddr),
      .PWRITE_s    (pwrite),
      .PWDATA_s    (pwdata),
      .PENABLE_s   (penable),
      .PSTRB_s     (pstrb),
      .PPROT_s     (pprot),
      .PRDATA_s    (o_prdata_s[k]),
      .PREADY_s    (o_pready_s[k]),
      .PSLVERR_s   (o_pslverr_s[k]),
      .PSEL_m      (o_psel_m[k]),
      .PADDR_m     (o_paddr_m[k]),
      .PWRITE_m    (o_pwrite_m[k]),
      .PWDATA_m    (o_pwdata_m[k]),
      .PENABLE_m   (o_penable_m[k]),
      .PSTRB_m     (o_pstrb_m[k]),
      .PPROT_m     (o_pprot_m[k]),
      .PRDATA_m    (prdata_m),
      .PREADY_m    (pready_m[k]),
      .PSLVERR_m   (pslverr_m),
      .GNT_IDX     (o_gnt[k]),
      .TIMEOUT_EVT (o_timeout[k])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int mode, input int ptr);
    for (int j = 0; j < NM; j++) begin
      int i = (mode == 1) ? j : (ptr + j) % NM;
      if (psel[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit m_timeout(input int k);
    return TO_EN && m_busy[k] && m_acc[k] && !pready_m[k] && (m_wait[k] == TO - 1);
  endfunction

  function automatic bit m_done(input int k);
    return m_busy[k] && m_acc[k] && (pready_m[k] || m_timeout(k));
  endfunction

  // Compare DUT outputs with the model, then advance the model across the coming edge.
  always @(negedge PCLK) begin
    for (int k = 0; k < 2; k++) begin
      bit done, to, rdy;
      done = m_done(k);
      to   = m_timeout(k);
      chk($sformatf("psel_m[%0d]", k),    32'(o_psel_m[k]),    32'(m_busy[k]));
      chk($sformatf("penable_m[%0d]", k), 32'(o_penable_m[k]), 32'(m_busy[k] && m_acc[k]));
      chk($sformatf("paddr_m[%0d]", k),   o_paddr_m[k],        m_addr[k]);
      chk($sformatf("pwdata_m[%0d]", k),  o_pwdata_m[k],       m_wdat[k]);
      chk($sformatf("pwrite_m[%0d]", k),  32'(o_pwrite_m[k]),  32'(m_wr[k]));
      chk($sformatf("pstrb_m[%0d]", k),   32'(o_pstrb_m[k]),   32'(m_strb[k]));
      chk($sformatf("pprot_m[%0d]", k),   32'(o_pprot_m[k]),   32'(m_prot[k]));
      chk($sformatf("gnt_idx[%0d]", k),   32'(o_gnt[k]),       32'(m_g[k]));
      chk($sformatf("timeout_evt[%0d]", k), 32'(o_timeout[k]), 32'(to));
      for (int i = 0; i < NM; i++) begin
        rdy = done && (i == m_g[k]);
        chk($sformatf("pready_s[%0d][%0d]", k, i), 32'(o_pready_s[k][i]), 32'(rdy));
        if (!m_busy[k] || i != m_g[k] || rdy) begin
          chk($sformatf("prdata_s[%0d][%0d]", k, i), o_prdata_s[k][i],
              (rdy && !to) ? prdata_m : 32'h0);
          chk($sformatf("pslverr_s[%0d][%0d]", k, i), 32'(o_pslverr_s[k][i]),
              32'(rdy && (to || pslverr_m)));
        end
        rcnt[k][i] += int'(o_pready_s[k][i]);
      end
      if (o_psel_m[k] && !o_penable_m[k]) begin
        if (k == 0) glog_rr.push_back(int'(o_gnt[k]));
        else        glog_fx.push_back(int'(o_gnt[k]));
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (PRESET) begin
        m_busy[k] = 0; m_acc[k] = 0; m_g[k] = 0; m_ptr[k] = 0; m_wait[k] = 0;
        m_addr[k] = '0; m_wdat[k] = '0; m_wr[k] = 0; m_strb[k] = '0; m_prot[k] = '0;
      end else if (!m_busy[k]) begin
        int w;
        w = pick(k, m_ptr[k]);
        if (w >= 0) begin
          m_busy[k] = 1; m_acc[k] = 0; m_g[k] = w;
          m_addr[k] = paddr[w]; m_wdat[k] = pwdata[w]; m_wr[k] = pwrite[w];
          m_strb[k] = pstrb[w]; m_prot[k] = pprot[w];
          if (k == 0) m_ptr[k] = (w + 1) % NM;
        end
      end else if (!m_acc[k]) begin
        m_acc[k]  = 1;
        m_wait[k] = 0;
      end else if (m_done(k)) begin
        m_busy[k] = 0;
        m_acc[k]  = 0;
      end else begin
        m_wait[k]++;
      end
    end
  end

  // Advance n cycles; the slave model raises PREADY_m after 'waits' stalled ACCESS cycles.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
      for (int k = 0; k < 2; k++)
        pready_m[k] = m_busy[k] && m_acc[k] && (m_wait[k] >= waits);
    end
  endtask

  task automatic chk_log(input string name, input int q [$], input int idx, input int exp);
    chk($sformatf("%s[%0d]", name, idx), (q.size() > idx) ? 32'(q[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    PRESET    = 1'b1;
    prdata_m  = 32'h0;
    pslverr_m = 1'b0;
    pready_m  = '{0, 0};
    for (int i = 0; i < NM; i++) begin
      psel[i] = 0; paddr[i] = 32'h1000 * (i + 1); pwrite[i] = 0; pwdata[i] = 32'hA0 + i;
      penable[i] = 0; pstrb[i] = 4'hF; pprot[i] = 3'(i);
      rcnt[0][i] = 0; rcnt[1][i] = 0;
    end

    // Reset values.
    tick(2);
    @(negedge PCLK);
    chk("reset psel_m", 32'(o_psel_m[0]), 32'h0);
    chk("reset gnt_idx", 32'(o_gnt[0]), 32'h0);
    chk("reset paddr_m", o_paddr_m[0], 32'h0);
    tick(1);
    PRESET = 1'b0;

    // Single write from master 2 with a zero-wait slave.
    tick(1);
    psel[2] = 1; paddr[2] = 32'h100; pwrite[2] = 1; pwdata[2] = 32'hDEAD_BEEF; pstrb[2] = 4'h3;
    @(negedge PCLK);
    chk("wr T psel_m", 32'(o_psel_m[0]), 32'h0);
    tick(1);
    paddr[2] = 32'h200;
    @(negedge PCLK);
    chk("wr T+1 psel_m", 32'(o_psel_m[0]), 32'h1);
    chk("wr T+1 penable_m", 32'(o_penable_m[0]), 32'h0);
    chk("wr T+1 paddr_m", o_paddr_m[0], 32'h100);
    chk("wr T+1 pwdata_m", o_pwdata_m[0], 32'hDEAD_BEEF);
    chk("wr T+1 pready_s2", 32'(o_pready_s[0][2]), 32'h0);
    tick(1);
    @(negedge PCLK);
    chk("wr T+2 penable_m", 32'(o_penable_m[0]), 32'h1);
    chk("wr T+2 paddr_m held", o_paddr_m[0], 32'h100);
    chk("wr T+2 pready_s2", 32'(o_pready_s[0][2]), 32'h1);
    tick(1);
    psel[2] = 0;
    @(negedge PCLK);
    chk("wr T+3 pready_s2", 32'(o_pready_s[0][2]), 32'h0);
    chk("wr T+3 psel_m", 32'(o_psel_m[0]), 32'h0);

    // Round-robin from a fresh pointer: masters 0,1,3 persistent.
    PRESET = 1'b1;
    tick(1);
    PRESET = 1'b0;
    glog_rr.delete(); glog_fx.delete();
    psel[0] = 1; psel[1] = 1; psel[3] = 1;
    tick(12);
    psel[0] = 0; psel[1] = 0; psel[3] = 0;
    tick(4);
    chk("rr grant count", 32'(glog_rr.size()), 32'd4);
    chk_log("rr order", glog_rr, 0, 0);
    chk_log("rr order", glog_rr, 1, 1);
    chk_log("rr order", glog_rr, 2, 3);
    chk_log("rr order", glog_rr, 3, 0);
    chk_log("fx order", glog_fx, 0, 0);
    chk_log("fx order", glog_fx, 3, 0);

    // Masters 1 and 3 persistent, master 1 drops after three transfers.
    glog_rr.delete(); glog_fx.delete();
    psel[1] = 1; psel[3] = 1;
    tick(9);
    psel[1] = 0;
    tick(3);
    psel[3] = 0;
    tick(4);
    chk("fx grant count", 32'(glog_fx.size()), 32'd4);
    chk_log("fx prio", glog_fx, 0, 1);
    chk_log("fx prio", glog_fx, 1, 1);
    chk_log("fx prio", glog_fx, 2, 1);
    chk_log("fx prio", glog_fx, 3, 3);
    chk_log("rr alt", glog_rr, 0, 1);
    chk_log("rr alt", glog_rr, 1, 3);
    chk_log("rr alt", glog_rr, 2, 1);
    chk_log("rr alt", glog_rr, 3, 3);

    // Read with 5 wait states and slave error; master 0 drops PSEL mid-transfer.
    for (int i = 0; i < NM; i++) begin rcnt[0][i] = 0; rcnt[1][i] = 0; end
    waits = 5; prdata_m = 32'h1234_5678; pslverr_m = 1;
    psel[0] = 1; pwrite[0] = 0; paddr[0] = 32'h40;
    tick(3);
    psel[0] = 0;
    tick(4);
    @(negedge PCLK);
    chk("rd pready_s0", 32'(o_pready_s[0][0]), 32'h1);
    chk("rd prdata_s0", o_prdata_s[0][0], 32'h1234_5678);
    chk("rd pslverr_s0", 32'(o_pslverr_s[0][0]), 32'h1);
    chk("rd prdata_s1", o_prdata_s[0][1], 32'h0);
    tick(4);
    chk("rd pready count m0", 32'(rcnt[0][0]), 32'd1);
    chk("rd pready count others", 32'(rcnt[0][1] + rcnt[0][2] + rcnt[0][3]), 32'd0);
    chk("rd pready count fx m0", 32'(rcnt[1][0]), 32'd1);
    pslverr_m = 0;

    // Reset during ACCESS drops the transfer and returns the pointer to 0.
    for (int i = 0; i < NM; i++) begin rcnt[0][i] = 0; rcnt[1][i] = 0; end
    waits = 3;
    psel[1] = 1; paddr[1] = 32'h80;
    tick(2);
    @(negedge PCLK);
    chk("rst-mid in access", 32'(o_penable_m[0]), 32'h1);
    tick(1);
    PRESET = 1'b1; psel[1] = 0;
    tick(1);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst-mid psel_m", 32'(o_psel_m[0]), 32'h0);
    chk("rst-mid penable_m", 32'(o_penable_m[0]), 32'h0);
    chk("rst-mid gnt_idx", 32'(o_gnt[0]), 32'h0);
    chk("rst-mid paddr_m", o_paddr_m[0], 32'h0);
    chk("rst-mid pready count", 32'(rcnt[0][1] + rcnt[1][1]), 32'd0);
    glog_rr.delete(); glog_fx.delete();
    waits = 0;
    tick(1);
    psel[0] = 1; psel[2] = 1;
    tick(6);
    psel[0] = 0; psel[2] = 0;
    tick(4);
    chk_log("rst-mid rr", glog_rr, 0, 0);
    chk_log("rst-mid rr", glog_rr, 1, 2);

`ifdef APB_MUX_TIMEOUT_EN
    // Slave never ready: watchdog completes on the 8th ACCESS cycle.
    waits = 1000; prdata_m = 32'hAAAA_5555;
    psel[3] = 1;
    tick(9);
    @(negedge PCLK);
    chk("to evt", 32'(o_timeout[0]), 32'h1);
    chk("to pready_s3", 32'(o_pready_s[0][3]), 32'h1);
    chk("to pslverr_s3", 32'(o_pslverr_s[0][3]), 32'h1);
    chk("to prdata_s3", o_prdata_s[0][3], 32'h0);
    tick(1);
    psel[3] = 0;
    @(negedge PCLK);
    chk("to evt pulse", 32'(o_timeout[0]), 32'h0);
    chk("to psel_m", 32'(o_psel_m[0]), 32'h0);
    waits = 0;
    tick(4);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
